// File: rtl/set_assoc_dcache.sv
// -----------------------------------------------------------------------------
// set_assoc_dcache
//   N-way set-associative, write-through / no-write-allocate L1 data cache.
//   It handles one LSQ request at a time over a valid/ready handshake, reads
//   whole lines from the memory port on a load miss, and sends every store
//   straight through to memory. Round-robin replacement is tracked per set.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   req_*                     LSQ request (valid/ready, we, size, unsigned,
//                             addr, wdata)
//   inv                       single-cycle pulse that invalidates every line
//                             (honoured in IDLE only)
//   resp_*                    one-cycle response (valid, rdata, hit, err)
//   mem_req_*                 memory request (line read or write-through)
//   mem_resp_valid/_data      refill line; byte 0 is at [7:0]
//   hit_count, miss_count     wrapping counters of lookups that hit/missed
// -----------------------------------------------------------------------------
module set_assoc_dcache #(
  parameter int ADDR_W     = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 128,
  parameter int LINE_BYTES = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [31:0]             req_wdata,
  input  logic                    inv,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_hit,
  output logic                    resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [1:0]              mem_req_size,
  output logic [31:0]             mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_resp_data,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_WT_REQ
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0]   data_mem [SETS][WAYS];
  logic [WAYS-1:0]     valid_q  [SETS];
  logic [WAY_W-1:0]    rr_q     [SETS];

  logic [TAG_W-1:0]    tag_r;
  logic [IDX_W-1:0]    idx_r;
  logic [OFF_W-1:0]    off_r;
  logic                misaligned;
  logic                lk_hit;
  logic [WAY_W-1:0]    lk_way;
  logic [WAY_W-1:0]    victim;
  logic                vic_found;
  logic [WAY_W-1:0]    rr_next;
  logic [LINE_W-1:0]   hit_line;

  // Array write controls produced by the FSM.
  logic                line_we;
  logic                fill;
  logic [WAY_W-1:0]    line_way;
  logic [LINE_W-1:0]   line_wdata;
  logic                inv_all;
  logic                rr_adv;

  assign tag_r = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_r = addr_q[OFF_W +: IDX_W];
  assign off_r = addr_q[OFF_W-1:0];

  // Half needs addr[0]=0; word (and the 11 encoding) needs addr[1:0]=0.
  assign misaligned = (size_q == 2'b01) ? addr_q[0] :
                      (size_q[1] ? (addr_q[1:0] != 2'b00) : 1'b0);

  // Select the addressed bytes of a line, then sign- or zero-extend them.
  function automatic logic [31:0] extract(input logic [LINE_W-1:0] line,
                                          input logic [OFF_W-1:0]  off,
                                          input logic [1:0]        size,
                                          input logic              uns);
    logic [LINE_W-1:0] sh;
    sh = line >> {off, 3'b000};
    case (size)
      2'b00:   extract = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'b01:   extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh[31:0];
    endcase
  endfunction

  // Overwrite the 1, 2 or 4 bytes a store touches; the rest of the line is kept.
  function automatic logic [LINE_W-1:0] merge_store(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [1:0]        size,
                                                    input logic [31:0]       wd);
    logic [LINE_W-1:0] m;
    int nb;
    m  = line;
    nb = (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
    for (int b = 0; b < 4; b++) begin
      if (b < nb) m[((int'(off) + b) & (LINE_BYTES - 1)) * 8 +: 8] = wd[b*8 +: 8];
    end
    return m;
  endfunction

  // Tag compare and victim choice for the set of the latched request.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    victim    = rr_q[idx_r];
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_r][w] && (tag_mem[idx_r][w] == tag_r)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (!vic_found && !valid_q[idx_r][w]) begin
        vic_found = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    rr_next = (rr_q[idx_r] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_r] + 1'b1;
  end

  assign hit_line = data_mem[idx_r][lk_way];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_hit   = 1'b0;
    resp_err   = 1'b0;
    line_we    = 1'b0;
    fill       = 1'b0;
    line_way   = lk_way;
    line_wdata = hit_line;
    inv_all    = 1'b0;
    rr_adv     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (inv) begin
          inv_all = 1'b1;
        end else if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (misaligned) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          state_d    = S_IDLE;
        end else begin
          if (lk_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
          else        miss_cnt_d = miss_cnt_q + 32'd1;
          hit_d = lk_hit;
          if (!we_q) begin
            if (lk_hit) begin
              resp_valid = 1'b1;
              resp_hit   = 1'b1;
              resp_rdata = extract(hit_line, off_r, size_q, uns_q);
              state_d    = S_IDLE;
            end else begin
              state_d = S_MISS_REQ;
            end
          end else begin
            // No write-allocate: only a resident line absorbs the store.
            if (lk_hit) begin
              line_we    = 1'b1;
              line_wdata = merge_store(hit_line, off_r, size_q, wdata_q);
            end
            state_d = S_WT_REQ;
          end
        end
      end

      S_MISS_REQ: begin
        if (mem_req_ready) state_d = S_MISS_WAIT;
      end

      S_MISS_WAIT: begin
        if (mem_resp_valid) begin
          line_we    = 1'b1;
          fill       = 1'b1;
          line_way   = victim;
          line_wdata = mem_resp_data;
          // The pointer only moves when a valid line is actually evicted.
          rr_adv     = !vic_found;
          resp_valid = 1'b1;
          resp_rdata = extract(mem_resp_data, off_r, size_q, uns_q);
          state_d    = S_IDLE;
        end
      end

      S_WT_REQ: begin
        if (mem_req_ready) begin
          resp_valid = 1'b1;
          resp_hit   = hit_q;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready     = (state_q == S_IDLE) && !inv;
  assign mem_req_valid = (state_q == S_MISS_REQ) || (state_q == S_WT_REQ);
  assign mem_req_we    = (state_q == S_WT_REQ);
  assign mem_req_addr  = (state_q == S_MISS_REQ) ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} :
                         ((state_q == S_WT_REQ) ? addr_q : '0);
  assign mem_req_size  = (state_q == S_WT_REQ) ? size_q  : 2'b00;
  assign mem_req_wdata = (state_q == S_WT_REQ) ? wdata_q : 32'h0;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (rstn && line_we) begin
      data_mem[idx_r][line_way] <= line_wdata;
      if (fill) tag_mem[idx_r][line_way] <= tag_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (inv_all) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (fill) begin
        valid_q[idx_r][line_way] <= 1'b1;
      end
      if (rr_adv) rr_q[idx_r] <= rr_next;
    end
  end

endmodule

// File: tb/tb_set_assoc_dcache.sv
// -----------------------------------------------------------------------------
// tb_set_assoc_dcache
//   Randomised and directed stimulus for set_assoc_dcache. The reference model
//   is a byte-addressed memory plus a per-set record of which tags are resident.
//   Expected responses and memory requests are queued when a request is issued.
//   Separate processes for the response monitor and the memory responder pop
//   the queues and compare.
// -----------------------------------------------------------------------------
module tb_set_assoc_dcache;

  localparam int ADDR_W     = 32;
  localparam int WAYS       = 4;
  localparam int SETS       = 128;
  localparam int LINE_BYTES = 64;
  localparam int LINE_W     = LINE_BYTES * 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              inv;
  logic              resp_valid, resp_hit, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [1:0]        mem_req_size;
  logic [31:0]       mem_req_wdata;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;
  logic [31:0]       hit_count, miss_count;

  always #5 clk = ~clk;

  set_assoc_dcache #(
    .ADDR_W(ADDR_W), .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .inv(inv),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct { logic [31:0] rdata; logic hit; logic err; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata; } mem_t;

  resp_t exp_q[$];
  mem_t  mem_q[$];

  int n_checks = 0;
  int n_errs   = 0;

  // Responder knobs.
  int stall      = 0;
  bit hold_resp  = 0;
  bit late_pulse = 0;

  // Reference model: backing memory and resident tags per set.
  logic [7:0]  mem_bytes [bit [31:0]];
  bit          mv  [SETS][WAYS];
  int unsigned mt  [SETS][WAYS];
  int          mrr [SETS];
  int unsigned m_hits, m_misses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem_bytes.exists(a)) return mem_bytes[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
      mrr[s] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_invalidate();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (!req_ready && c < 200) begin @(posedge clk); #1; c++; end
    if (!req_ready) fail_now("req_ready_timeout");
  endtask

  // Predict the outcome from the model, queue it, and perform the handshake.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    resp_t       r;
    mem_t        m;
    int          nb, set_i, way;
    int unsigned tag;
    bit          hit;
    logic [31:0] v;
    nb = (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
    r  = '{rdata: 32'h0, hit: 1'b0, err: 1'b0};
    if (addr % nb != 0) begin
      r.err = 1'b1;
    end else begin
      set_i = int'((addr / LINE_BYTES) % SETS);
      tag   = addr / (LINE_BYTES * SETS);
      hit   = 0;
      for (int w = 0; w < WAYS; w++) if (mv[set_i][w] && mt[set_i][w] == tag) hit = 1;
      if (hit) m_hits++; else m_misses++;
      r.hit = hit;
      if (!we) begin
        v = 0;
        for (int b = 0; b < nb; b++) v = v + (32'(mem_rd(addr + b)) << (8 * b));
        if (!uns && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        r.rdata = v;
        if (!hit) begin
          m = '{we: 1'b0, addr: addr & ~32'(LINE_BYTES - 1), size: size, wdata: 32'h0};
          mem_q.push_back(m);
          way = -1;
          for (int w = 0; w < WAYS; w++) if (way < 0 && !mv[set_i][w]) way = w;
          if (way < 0) begin
            way = mrr[set_i];
            mrr[set_i] = (mrr[set_i] + 1) % WAYS;
          end
          mv[set_i][way] = 1;
          mt[set_i][way] = tag;
        end
      end else begin
        for (int b = 0; b < nb; b++) mem_bytes[addr + b] = wdata[8*b +: 8];
        m = '{we: 1'b1, addr: addr, size: size, wdata: wdata};
        mem_q.push_back(m);
      end
    end
    exp_q.push_back(r);
    wait_idle();
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk); #1;
    req_valid    = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (exp_q.size() != 0 && c < 1000) begin @(posedge clk); #1; c++; end
    if (exp_q.size() != 0) begin
      fail_now("resp_timeout");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic op(input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wdata);
    issue(we, size, uns, addr, wdata);
    wait_done();
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    check({tag, "_hit_count"},  hit_count,  m_hits);
    check({tag, "_miss_count"}, miss_count, m_misses);
    @(posedge clk); #1;
  endtask

  // A request presented alongside inv must not be accepted.
  task automatic do_inv();
    wait_idle();
    inv       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0000_1040;
    @(negedge clk);
    check("inv_req_ready", req_ready, 32'd0);
    @(posedge clk); #1;
    inv       = 1'b0;
    req_valid = 1'b0;
    model_invalidate();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Response monitor.
  always @(negedge clk) begin : monitor
    resp_t r;
    if (rstn && resp_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_resp");
      end else begin
        r = exp_q.pop_front();
        check("resp_err",   resp_err,   r.err);
        check("resp_hit",   resp_hit,   r.hit);
        check("resp_rdata", resp_rdata, r.rdata);
      end
    end
  end

  // Memory responder: checks requests on acceptance and returns refill lines.
  initial begin : responder
    mem_t              e;
    logic [LINE_W-1:0] line;
    int                delay;
    delay          = 0;
    line           = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rstn && mem_req_valid && mem_req_ready) begin
        if (mem_q.size() == 0) begin
          fail_now("unexpected_mem_req");
        end else begin
          e = mem_q.pop_front();
          check("mem_we",   mem_req_we,   e.we);
          check("mem_addr", mem_req_addr, e.addr);
          if (e.we) begin
            check("mem_size",  mem_req_size,  e.size);
            check("mem_wdata", mem_req_wdata, e.wdata);
          end else begin
            for (int b = 0; b < LINE_BYTES; b++) line[8*b +: 8] = mem_rd(e.addr + b);
            delay = $urandom_range(1, 4);
          end
        end
      end
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (!rstn) delay = 0;
      if (late_pulse) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = '1;
        late_pulse     = 0;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          if (hold_resp) delay = 1;
          else begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = line;
          end
        end
      end
      mem_req_ready = (stall > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (stall > 0) stall--;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stimulus
    int c;
    int sel [4] = '{0, 16, 65, 127};
    logic [31:0] a;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; inv = 1'b0;
    model_reset();
    mem_bytes[32'h0000_1040] = 8'hEF;
    mem_bytes[32'h0000_1041] = 8'hBE;
    mem_bytes[32'h0000_1042] = 8'hAD;
    mem_bytes[32'h0000_1043] = 8'hDE;
    mem_bytes[32'h0000_2000] = 8'h80;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_req_ready",     req_ready,     32'd1);
    check("rst_resp_valid",    resp_valid,    32'd0);
    check("rst_mem_req_valid", mem_req_valid, 32'd0);
    check("rst_hit_count",     hit_count,     32'd0);
    check("rst_miss_count",    miss_count,    32'd0);
    @(posedge clk); #1;

    // Miss then hit on the same word.
    op(1'b0, 2'b10, 1'b0, 32'h0000_1040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_1040, 32'h0);
    @(negedge clk);
    check("t1_hit_count",  hit_count,  32'd1);
    check("t1_miss_count", miss_count, 32'd1);
    @(posedge clk); #1;

    // Store byte hit, then reload the merged word.
    op(1'b1, 2'b00, 1'b0, 32'h0000_1041, 32'h0000_00AB);
    op(1'b0, 2'b10, 1'b0, 32'h0000_1040, 32'h0);

    // Fill set 0x41, then evict in round-robin order.
    op(1'b0, 2'b10, 1'b0, 32'h0000_3040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_5040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_7040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_9040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_1040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_5040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_3040, 32'h0);
    check_counters("t3");

    // Sign control and a misaligned half.
    op(1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0);
    op(1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0);
    op(1'b0, 2'b00, 1'b1, 32'h0000_2000, 32'h0);
    op(1'b0, 2'b01, 1'b0, 32'h0000_1041, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_2002, 32'h0);
    check_counters("t4");

    // Stall the memory port, then reset while waiting for the refill.
    hold_resp = 1;
    stall     = 20;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_B080, 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_mem_valid", mem_req_valid, 32'd1);
      check("stall_mem_addr",  mem_req_addr,  32'h0000_B080);
      check("stall_req_ready", req_ready,     32'd0);
      @(posedge clk); #1;
    end
    c = 0;
    while (mem_req_valid && c < 100) begin @(posedge clk); #1; c++; end
    if (mem_req_valid) fail_now("miss_req_timeout");
    rstn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check("mid_rst_req_ready",     req_ready,     32'd1);
    check("mid_rst_mem_req_valid", mem_req_valid, 32'd0);
    check("mid_rst_hit_count",     hit_count,     32'd0);
    @(posedge clk); #1;
    hold_resp  = 0;
    late_pulse = 1;
    repeat (3) begin @(posedge clk); #1; end
    op(1'b0, 2'b10, 1'b0, 32'h0000_B080, 32'h0);
    check_counters("t5");

    // Global invalidate.
    op(1'b0, 2'b10, 1'b0, 32'h0000_1040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_2080, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_30C0, 32'h0);
    do_inv();
    op(1'b0, 2'b10, 1'b0, 32'h0000_1040, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_2080, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_30C0, 32'h0);
    check_counters("t6");

    // Random traffic over a few sets with more tags than ways.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_inv();
      end else begin
        a = (32'($urandom_range(0, 5)) << 13) |
            (32'(sel[$urandom_range(0, 3)]) << 6) |
            32'($urandom_range(0, 63));
        op($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    check_counters("final");
    check("mem_q_drained", mem_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
